dff_serial_sched: RTL
=====================

// Module: dff_serial_sched
// PURPOSE
//  Round-robin scheduler for a shared parallel-in/serial-out flip-flop register.
//  - Two requesters each offer a WIDTH-bit word.
//  - Grants one requester at a time.
//  - Loads the granted word into the shared register.
//  - Shifts it out MSB-first, one bit per clk, with framing strobes.
//  - Sits between local word producers and a single-bit serial link.
// PARAMETERS
//  WIDTH  8  word length in bits, legal range >= 2
//  CNT_W  $clog2(WIDTH)  localparam, width of the bit counter
// PORTS
//  clk         in   1      single clock, rising-edge
//  rst         in   1      asynchronous, active-high reset
//  req0        in   1      requester 0 has a word pending
//  data0       in   WIDTH  requester 0 word, held stable while req0=1
//  req1        in   1      requester 1 has a word pending
//  data1       in   WIDTH  requester 1 word, held stable while req1=1
//  gnt0        out  1      1-cycle pulse: data0 captured
//  gnt1        out  1      1-cycle pulse: data1 captured
//  sout        out  1      serial data bit
//  sout_valid  out  1      sout carries a valid bit this cycle
//  sof         out  1      first bit (MSB) of a word
//  eof         out  1      last bit (LSB) of a word
//  src         out  1      requester index of the word being shifted
//  busy        out  1      a word is in flight
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset (async, immediate): all outputs 0, state IDLE, counter 0, shift register 0.
//    Priority pointer is set so req0 wins the first contention.
//  - Two states: IDLE and SHIFT.
//  - IDLE, on an edge with any req=1:
//    - Grant the selected requester and load its data into the shift register.
//    - Go to SHIFT with cnt=0.
//    - In the following cycle: gnt_x=1, sout_valid=1, sof=1, sout=data[WIDTH-1], busy=1.
//  - Selection:
//    - A single req wins.
//    - If both are set, the requester NOT granted last wins; the pointer updates on every grant.
//  - SHIFT, each edge: shift left one, cnt+1.
//    - Bit k (0=MSB) is presented in the k-th valid cycle.
//    - eof=1 when cnt==WIDTH-1.
//  - Word latency: grant edge -> MSB next cycle; the word occupies exactly WIDTH valid cycles.
//  - End of word (edge where cnt==WIDTH-1):
//    - If any req=1, arbitrate and load immediately. sout_valid stays 1 with zero gap, and
//      sof coincides with the next word's MSB.
//    - Otherwise go to IDLE: sout_valid, busy and sout drop to 0.
//  - Handshake rules:
//    - gnt_x is high for exactly 1 cycle per word.
//    - The requester must drop req_x, or present a new word, on the edge ending the gnt cycle.
//    - A req still high after that edge is treated as a new word.
//    - req/data changes during SHIFT have no effect on the word in flight.
//  - gnt0 and gnt1 are never high together.
//  - sof and eof are mutually exclusive (WIDTH >= 2).
//  - src is valid whenever sout_valid=1, else 0.
//  - Reset mid-word aborts it: no eof, and the word is discarded. After release, behaviour
//    is as from power-up.
// STRUCTURE
//  - Shared package dff_serial_pkg holds:
//    - state encoding: IDLE=1'b0, SHIFT=1'b1
//    - default WIDTH constant
//    - requester-index constants REQ0=0, REQ1=1
//  - Sub-module piso_shift_reg (WIDTH) is the shared datapath:
//    - inputs: load, shift_en, din[WIDTH], clk, rst
//    - output: msb
//  - The scheduler owns the FSM, counter, arbiter pointer and strobes.
// TESTING
//  - Reset: rst=1 mid-run -> all outputs 0 the same timestep. Release, req0+req1 together
//    -> gnt0 first.
//  - Single word: req0=1, data0=8'hA5 -> gnt0 pulse; sout 1,0,1,0,0,1,0,1 over 8 valid
//    cycles; sof on 1st, eof on 8th; busy drops after.
//  - Contention: req0 and req1 held with new words each grant, data0=8'hF0, data1=8'h0F
//    -> grants alternate 0,1,0,1; 32 contiguous valid cycles; src toggles every 8.
//  - Back-to-back: req1 asserted during the eof cycle -> next cycle sof=1, src=1, no idle gap.
//  - Abort: rst pulse at bit 3 of 8'hC3 -> no eof. Next word 8'h81 is shifted intact.
//  - Stability: change data0 during SHIFT -> the word in flight is unchanged. Check that
//    gnt0&gnt1 is never 1 and sof&eof is never 1.

Source files
------------

// File: rtl/dff_serial_pkg.sv
// rtl/dff_serial_pkg.sv - shared types and constants for the serial scheduler
package dff_serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int   DEFAULT_WIDTH = 8;
    localparam logic REQ0          = 1'b0;
    localparam logic REQ1          = 1'b1;

endpackage

// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - parallel-in serial-out register, MSB first
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] r_data;

    // Zeros shift in from the LSB end, so a fully drained word leaves msb low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= din;
        end else if (shift_en) begin
            r_data <= {r_data[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = r_data[WIDTH-1];

endmodule

// File: rtl/dff_serial_sched.sv
// rtl/dff_serial_sched.sv - round-robin arbiter feeding one shared PISO register
module dff_serial_sched
    import dff_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sout,
    output logic             sout_valid,
    output logic             sof,
    output logic             eof,
    output logic             src,
    output logic             busy
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic             r_last, w_last_nxt;
    logic             w_gnt0_nxt, w_gnt1_nxt, w_valid_nxt, w_sof_nxt, w_eof_nxt;
    logic             w_src_nxt, w_busy_nxt;
    logic             w_any, w_sel, w_end, w_accept, w_load, w_shift;
    logic [WIDTH-1:0] w_din;

    // On contention the requester that was not granted last wins.
    assign w_any    = req0 | req1;
    assign w_sel    = (req0 & req1) ? ~r_last : req1;
    assign w_end    = (r_state == SHIFT) && (r_cnt == CNT_LAST);
    assign w_accept = w_any && ((r_state == IDLE) || w_end);
    assign w_load   = w_accept;
    assign w_shift  = (r_state == SHIFT) && !w_accept;
    assign w_din    = (w_sel == REQ1) ? data1 : data0;
    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_gnt0_nxt  = 1'b0;
        w_gnt1_nxt  = 1'b0;
        w_valid_nxt = 1'b0;
        w_sof_nxt   = 1'b0;
        w_eof_nxt   = 1'b0;
        w_src_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
        if (w_accept) begin
            w_state_nxt = SHIFT;
            w_cnt_nxt   = '0;
            w_last_nxt  = w_sel;
            w_gnt0_nxt  = (w_sel == REQ0);
            w_gnt1_nxt  = (w_sel == REQ1);
            w_valid_nxt = 1'b1;
            w_sof_nxt   = 1'b1;
            w_src_nxt   = w_sel;
            w_busy_nxt  = 1'b1;
        end else if (w_end) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else if (r_state == SHIFT) begin
            w_cnt_nxt   = w_cnt_inc;
            w_valid_nxt = 1'b1;
            w_eof_nxt   = (w_cnt_inc == CNT_LAST);
            w_src_nxt   = src;
            w_busy_nxt  = 1'b1;
        end
    end

    // r_last starts at REQ1 so requester 0 wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_last     <= REQ1;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            sout_valid <= 1'b0;
            sof        <= 1'b0;
            eof        <= 1'b0;
            src        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_last     <= w_last_nxt;
            gnt0       <= w_gnt0_nxt;
            gnt1       <= w_gnt1_nxt;
            sout_valid <= w_valid_nxt;
            sof        <= w_sof_nxt;
            eof        <= w_eof_nxt;
            src        <= w_src_nxt;
            busy       <= w_busy_nxt;
        end
    end

    piso_shift_reg #(
        .WIDTH(WIDTH)
    ) u_piso (
        .clk     (clk),
        .rst     (rst),
        .load    (w_load),
        .shift_en(w_shift),
        .din     (w_din),
        .msb     (sout)
    );

endmodule
